oldland_lsu: RTL
================

OLDLAND_LSU -- requirements
Module: oldland_lsu

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data bus width in bits; only 32 or 64 are legal.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning bus-wait cycles before fault; 0 disables the timeout.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1, the clock.
REQ-005 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 The block SHALL have ports load and store, input, 1 each, the access request; both high together is illegal.
REQ-007 The block SHALL have ports signed_ld (input, 1) and width (input, 2), meaning sign-extend select and access size: 00 byte, 01 half, 10 word, 11 double.
REQ-008 The block SHALL have ports addr (input, 32), mdr (input, DW) and wr_val (input, DW), meaning byte address, store data and non-memory bypass value.
REQ-009 The block SHALL have ports update_rd (input, 1) and rd_sel (input, 3), the writeback control.
REQ-010 The block SHALL have ports stall (output, 1), reg_wr_val (output, DW), update_rd_out (output, 1), rd_sel_out (output, 3), complete (output, 1), fault (output, 1) and fault_addr (output, 32).
REQ-011 The block SHALL have bus ports d_addr (output, 32), d_bytesel (output, DW/8), d_wr_en (output, 1), d_wr_val (output, DW), d_access (output, 1), d_data (input, DW), d_ack (input, 1) and d_error (input, 1).

Function
REQ-012 The block SHALL accept a request in any cycle with (load|store) high and stall low.
REQ-013 The block SHALL ignore all inputs while stall is high; upstream holds them.
REQ-014 The FSM SHALL have states IDLE, BUS and DONE.
- IDLE to BUS on an aligned accept.
- BUS to DONE on d_ack, d_error or timeout.
- DONE to IDLE after one cycle.
REQ-015 A request SHALL be misaligned if any of the following holds; it then never enters BUS and issues no bus cycle:
- half with addr[0] set;
- word with addr[1:0] nonzero;
- double with addr[2:0] nonzero;
- width 11 when DW=32.
REQ-016 A misaligned request SHALL pulse fault in the cycle after accept, with fault_addr = addr, complete = 0 and update_rd_out = 0.
REQ-017 Bus outputs SHALL be registered; d_access SHALL be high from cycle N+1 after an accept in cycle N through the terminating cycle inclusive.
REQ-018 d_addr SHALL be addr with its low log2(DW/8) bits cleared.
REQ-019 d_wr_en SHALL equal the captured store.
REQ-020 For lane offset o = addr[log2(DW/8)-1:0]:
- d_bytesel SHALL be the size mask (1, 3, F, FF) shifted left by o;
- d_wr_val SHALL be mdr shifted left by 8*o.
REQ-021 For load data, d_data SHALL be shifted right by 8*o, truncated to the access size, then zero- or sign-extended to DW per the captured signed_ld.
REQ-022 Read data SHALL be registered on the d_ack cycle and held on reg_wr_val during DONE.
REQ-023 In DONE after d_ack, complete SHALL pulse for one cycle, with update_rd_out = 1 for a load and 0 for a store, and rd_sel_out = the captured rd_sel.
REQ-024 When d_error and d_ack are high in the same cycle, d_error SHALL take priority.
REQ-025 On d_error, or when TIMEOUT>0 and the wait counter reaches TIMEOUT with no ack, DONE SHALL pulse fault with fault_addr = captured addr, complete = 0 and update_rd_out = 0.
REQ-026 stall SHALL be high in BUS and DONE, and low in IDLE.
REQ-027 A non-memory instruction in IDLE SHALL register wr_val, update_rd and rd_sel to the outputs with one-cycle latency, with complete = 0.
REQ-028 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide, clear on entering BUS and saturate.

Reset
REQ-029 While rst is high, the FSM SHALL go to IDLE and every output SHALL be 0 on the next edge: stall, complete, fault, fault_addr, update_rd_out, rd_sel_out, reg_wr_val, d_access, d_wr_en, d_bytesel, d_addr and d_wr_val.
REQ-030 A reset mid-BUS SHALL drop d_access on the next edge and produce no complete or fault; a late d_ack SHALL be ignored.

Structure
REQ-031 Package oldland_lsu_pkg SHALL hold the width encodings, the FSM state enum and the size-to-mask function.
REQ-032 Lane shift, mask and extension SHALL live in combinational sub-module oldland_lsu_lane, instantiated once.

Verification
REQ-033 DW=32, signed byte load at addr 0x103, d_data 0x80FF_FFFF, ack after 3 wait cycles -> d_bytesel 1000; reg_wr_val 0xFFFF_FF80; complete pulses once; stall high for 5 cycles.
REQ-034 DW=32, half store of mdr 0x0000_BEEF at addr 0x2002 -> d_addr 0x2000, d_bytesel 1100, d_wr_val 0xBEEF_0000, d_wr_en 1; update_rd_out 0.
REQ-035 DW=32, word load at addr 0x1001 -> no d_access; fault pulses next cycle with fault_addr 0x1001.
REQ-036 TIMEOUT=4, load with no ack -> fault after 4 wait cycles; d_access drops; stall low afterwards.
REQ-037 d_ack and d_error high together -> fault 1, complete 0; rst asserted in BUS -> all outputs 0 next cycle and a subsequent ack ignored.
REQ-038 DW=64, double load at addr 0x8, d_data 0x1122_3344_5566_7788 -> d_bytesel FF; reg_wr_val equals d_data.

Source files
------------

// File: rtl/oldland_lsu_pkg.sv
// rtl/oldland_lsu_pkg.sv - shared encodings, FSM states and size-mask helper for the load/store unit
package oldland_lsu_pkg;

  localparam logic [1:0] W_BYTE   = 2'b00;
  localparam logic [1:0] W_HALF   = 2'b01;
  localparam logic [1:0] W_WORD   = 2'b10;
  localparam logic [1:0] W_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  function automatic logic [7:0] size_mask(input logic [1:0] width);
    case (width)
      W_BYTE:  size_mask = 8'h01;
      W_HALF:  size_mask = 8'h03;
      W_WORD:  size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/oldland_lsu_lane.sv
// rtl/oldland_lsu_lane.sv - byte-lane steering: store shift/bytesel and load shift/truncate/extend
module oldland_lsu_lane
  import oldland_lsu_pkg::*;
#(
  parameter int DW = 32,
  localparam int BW = DW / 8,
  localparam int OW = $clog2(BW)
) (
  input  logic [1:0]    width_i,
  input  logic          signed_ld_i,
  input  logic [OW-1:0] offset_i,
  input  logic [DW-1:0] mdr_i,
  input  logic [DW-1:0] d_data_i,
  output logic [BW-1:0] bytesel_o,
  output logic [DW-1:0] wr_val_o,
  output logic [DW-1:0] rd_val_o
);

  logic [BW-1:0] mask;
  logic [DW-1:0] shifted;
  logic [DW-1:0] keep;
  logic          sign;

  always_comb begin
    mask      = BW'(size_mask(width_i));
    bytesel_o = mask << offset_i;
    wr_val_o  = mdr_i << {offset_i, 3'b000};
    shifted   = d_data_i >> {offset_i, 3'b000};
    keep      = '0;
    for (int i = 0; i < BW; i++) begin
      keep[8*i +: 8] = {8{mask[i]}};
    end
    case (width_i)
      W_BYTE:  sign = shifted[7];
      W_HALF:  sign = shifted[15];
      W_WORD:  sign = shifted[31];
      default: sign = 1'b0;
    endcase
    // Bits outside the access size are filled with the sign bit or zero.
    rd_val_o = (shifted & keep) | ({DW{signed_ld_i & sign}} & ~keep);
  end

endmodule

// File: rtl/oldland_lsu.sv
// rtl/oldland_lsu.sv - load/store unit: alignment check, registered data-bus cycle, writeback and faults
module oldland_lsu
  import oldland_lsu_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            store,
  input  logic            signed_ld,
  input  logic [1:0]      width,
  input  logic [31:0]     addr,
  input  logic [DW-1:0]   mdr,
  input  logic [DW-1:0]   wr_val,
  input  logic            update_rd,
  input  logic [2:0]      rd_sel,
  output logic            stall,
  output logic [DW-1:0]   reg_wr_val,
  output logic            update_rd_out,
  output logic [2:0]      rd_sel_out,
  output logic            complete,
  output logic            fault,
  output logic [31:0]     fault_addr,
  output logic [31:0]     d_addr,
  output logic [DW/8-1:0] d_bytesel,
  output logic            d_wr_en,
  output logic [DW-1:0]   d_wr_val,
  output logic            d_access,
  input  logic [DW-1:0]   d_data,
  input  logic            d_ack,
  input  logic            d_error
);

  localparam int BW = DW / 8;
  localparam int OW = $clog2(BW);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state_q;
  logic [31:0]     addr_q;
  logic [1:0]      width_q;
  logic            signed_q;
  logic            load_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            stall_q, complete_q, fault_q, update_rd_q, d_access_q, d_wr_en_q;
  logic [DW-1:0]   reg_wr_val_q, d_wr_val_q;
  logic [2:0]      rd_sel_out_q;
  logic [31:0]     fault_addr_q, d_addr_q;
  logic [BW-1:0]   d_bytesel_q;

  logic            misaligned;
  logic            timeout_hit;
  logic [1:0]      lane_width;
  logic [OW-1:0]   lane_off;
  logic [BW-1:0]   lane_bytesel;
  logic [DW-1:0]   lane_wr_val;
  logic [DW-1:0]   lane_rd_val;

  always_comb begin
    case (width)
      W_BYTE:  misaligned = 1'b0;
      W_HALF:  misaligned = addr[0];
      W_WORD:  misaligned = |addr[1:0];
      default: misaligned = (DW == 32) || (|addr[2:0]);
    endcase
    // The lane is shared: live request fields in IDLE, captured ones while on the bus.
    lane_width  = (state_q == S_IDLE) ? width : width_q;
    lane_off    = (state_q == S_IDLE) ? addr[OW-1:0] : addr_q[OW-1:0];
    cnt_d       = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    timeout_hit = (TIMEOUT > 0) && (cnt_d == CW'(TIMEOUT));
  end

  oldland_lsu_lane #(.DW(DW)) u_lane (
    .width_i     (lane_width),
    .signed_ld_i (signed_q),
    .offset_i    (lane_off),
    .mdr_i       (mdr),
    .d_data_i    (d_data),
    .bytesel_o   (lane_bytesel),
    .wr_val_o    (lane_wr_val),
    .rd_val_o    (lane_rd_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      width_q      <= '0;
      signed_q     <= 1'b0;
      load_q       <= 1'b0;
      cnt_q        <= '0;
      stall_q      <= 1'b0;
      complete_q   <= 1'b0;
      fault_q      <= 1'b0;
      update_rd_q  <= 1'b0;
      d_access_q   <= 1'b0;
      d_wr_en_q    <= 1'b0;
      reg_wr_val_q <= '0;
      d_wr_val_q   <= '0;
      rd_sel_out_q <= '0;
      fault_addr_q <= '0;
      d_addr_q     <= '0;
      d_bytesel_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          complete_q <= 1'b0;
          fault_q    <= 1'b0;
          if (load || store) begin
            update_rd_q  <= 1'b0;
            rd_sel_out_q <= rd_sel;
            if (misaligned) begin
              fault_q      <= 1'b1;
              fault_addr_q <= addr;
            end else begin
              state_q     <= S_BUS;
              stall_q     <= 1'b1;
              d_access_q  <= 1'b1;
              d_addr_q    <= {addr[31:OW], {OW{1'b0}}};
              d_bytesel_q <= lane_bytesel;
              d_wr_val_q  <= lane_wr_val;
              d_wr_en_q   <= store;
              addr_q      <= addr;
              width_q     <= width;
              signed_q    <= signed_ld;
              load_q      <= load;
              cnt_q       <= '0;
            end
          end else begin
            reg_wr_val_q <= wr_val;
            update_rd_q  <= update_rd;
            rd_sel_out_q <= rd_sel;
          end
        end
        S_BUS: begin
          if (d_error || d_ack || timeout_hit) begin
            state_q    <= S_DONE;
            d_access_q <= 1'b0;
            if (d_error || !d_ack) begin
              fault_q      <= 1'b1;
              fault_addr_q <= addr_q;
            end else begin
              complete_q  <= 1'b1;
              update_rd_q <= load_q;
              if (load_q) reg_wr_val_q <= lane_rd_val;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          stall_q     <= 1'b0;
          complete_q  <= 1'b0;
          fault_q     <= 1'b0;
          update_rd_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall         = stall_q;
  assign reg_wr_val    = reg_wr_val_q;
  assign update_rd_out = update_rd_q;
  assign rd_sel_out    = rd_sel_out_q;
  assign complete      = complete_q;
  assign fault         = fault_q;
  assign fault_addr    = fault_addr_q;
  assign d_addr        = d_addr_q;
  assign d_bytesel     = d_bytesel_q;
  assign d_wr_en       = d_wr_en_q;
  assign d_wr_val      = d_wr_val_q;
  assign d_access      = d_access_q;

endmodule
